apb_lite_master12: RTL and testbench

APB_LITE_MASTER12 -- requirements
Module: apb_lite_master12

---
 rtl/apb_lite_master12.sv | 171 +++++++++++++++++
 tb/tb_apb_lite_master12.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_lite_master12.sv
// APB-lite master: turns one command into a SETUP/ACCESS transfer on one of four slaves.
// Optional feature macro APB_PREADY_EN adds the pready12 port, wait states and a 16-cycle timeout.
module apb_lite_master12 (
    input  logic         pclk12,
    input  logic         p_reset12,
    input  logic         cmd_valid12,
    output logic         cmd_ready12,
    input  logic         cmd_write12,
    input  logic [7:0]   cmd_addr12,
    input  logic [31:0]  cmd_wdata12,
    output logic         rsp_valid12,
    output logic [31:0]  rsp_rdata12,
    output logic         rsp_err12,
    output logic [3:0]   psel12,
    output logic         penable12,
    output logic         pwrite12,
    output logic [5:0]   paddr12,
    output logic [31:0]  pwdata12,
    input  logic [127:0] prdata_bus12
`ifdef APB_PREADY_EN
    ,
    input  logic         pready12
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NSLV   = 4;
    localparam int unsigned IDX_W  = 2;
`ifdef APB_PREADY_EN
    localparam int unsigned CNT_W  = 4;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NSLV-1:0]     psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                done;
    logic                timeout;
`ifdef APB_PREADY_EN
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Reset blocks acceptance in the same cycle so nothing is captured while resetting.
    assign cmd_ready12 = (state_q == IDLE) && !p_reset12;

    assign psel12      = psel_q;
    assign penable12   = penable_q;
    assign pwrite12    = pwrite_q;
    assign paddr12     = paddr_q;
    assign pwdata12    = pwdata_q;
    assign rsp_valid12 = rsp_valid_q;
    assign rsp_rdata12 = rsp_rdata_q;
`ifdef APB_PREADY_EN
    assign rsp_err12   = rsp_err_q;
`else
    assign rsp_err12   = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        done        = 1'b0;
        timeout     = 1'b0;
`ifdef APB_PREADY_EN
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid12) begin
                    state_d  = SETUP;
                    sel_d    = cmd_addr12[7:6];
                    psel_d   = NSLV'(1) << cmd_addr12[7:6];
                    paddr_d  = cmd_addr12[5:0];
                    pwrite_d = cmd_write12;
                    pwdata_d = cmd_wdata12;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
`ifdef APB_PREADY_EN
                // cnt_q holds the number of earlier stalled ACCESS cycles.
                if (pready12) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_W'(15)) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                done = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            state_d     = IDLE;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (pwrite_q || timeout) ? '0 : prdata_bus12[{sel_q, 5'd0} +: DATA_W];
`ifdef APB_PREADY_EN
            rsp_err_d   = timeout;
            cnt_d       = '0;
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk12) begin
        if (p_reset12) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_PREADY_EN
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_PREADY_EN
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_lite_master12.sv
// Directed bench for apb_lite_master12; wait-state tests build only with APB_PREADY_EN.
module tb_apb_lite_master12;

    logic         pclk12 = 1'b0;
    logic         p_reset12;
    logic         cmd_valid12;
    logic         cmd_ready12;
    logic         cmd_write12;
    logic [7:0]   cmd_addr12;
    logic [31:0]  cmd_wdata12;
    logic         rsp_valid12;
    logic [31:0]  rsp_rdata12;
    logic         rsp_err12;
    logic [3:0]   psel12;
    logic         penable12;
    logic         pwrite12;
    logic [5:0]   paddr12;
    logic [31:0]  pwdata12;
    logic [127:0] prdata_bus12;
`ifdef APB_PREADY_EN
    logic         pready12;
`endif

    int n_cmp = 0;
    int n_err = 0;

    apb_lite_master12 dut (
        .pclk12       (pclk12),
        .p_reset12    (p_reset12),
        .cmd_valid12  (cmd_valid12),
        .cmd_ready12  (cmd_ready12),
        .cmd_write12  (cmd_write12),
        .cmd_addr12   (cmd_addr12),
        .cmd_wdata12  (cmd_wdata12),
        .rsp_valid12  (rsp_valid12),
        .rsp_rdata12  (rsp_rdata12),
        .rsp_err12    (rsp_err12),
        .psel12       (psel12),
        .penable12    (penable12),
        .pwrite12     (pwrite12),
        .paddr12      (paddr12),
        .pwdata12     (pwdata12),
        .prdata_bus12 (prdata_bus12)
`ifdef APB_PREADY_EN
        ,
        .pready12     (pready12)
`endif
    );

    always #5 pclk12 = ~pclk12;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk12);
        #1;
    endtask

    // Bus view packed as {psel, penable, pwrite, paddr}.
    function automatic logic [11:0] bus();
        return {psel12, penable12, pwrite12, paddr12};
    endfunction

    task automatic test_reset();
        p_reset12 = 1'b1;
        cmd_valid12 = 1'b0; cmd_write12 = 1'b0; cmd_addr12 = 8'h00; cmd_wdata12 = 32'h0;
        tick(); tick();
        n_cmp++;
        if (bus() !== 12'h000) begin n_err++; $display("FAIL reset_bus got %h exp %h", bus(), 12'h000); end
        n_cmp++;
        if (pwdata12 !== 32'h0) begin n_err++; $display("FAIL reset_pwdata got %h exp 0", pwdata12); end
        n_cmp++;
        if ({rsp_valid12, rsp_err12, rsp_rdata12} !== 34'h0) begin
            n_err++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp all 0", rsp_valid12, rsp_err12, rsp_rdata12);
        end
        n_cmp++;
        if (cmd_ready12 !== 1'b0) begin n_err++; $display("FAIL reset_ready_during got %b exp 0", cmd_ready12); end
        p_reset12 = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready12 !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b exp 1", cmd_ready12); end
    endtask

    task automatic test_write();
        cmd_valid12 = 1'b1; cmd_write12 = 1'b1; cmd_addr12 = 8'h44; cmd_wdata12 = 32'hDEADBEEF;
        tick();
        cmd_valid12 = 1'b0; cmd_addr12 = 8'hFF; cmd_wdata12 = 32'h0; cmd_write12 = 1'b0;
        n_cmp++;
        if (bus() !== {4'b0010, 1'b0, 1'b1, 6'h04}) begin
            n_err++; $display("FAIL wr_setup got %h exp %h", bus(), {4'b0010, 1'b0, 1'b1, 6'h04});
        end
        n_cmp++;
        if ({cmd_ready12, pwdata12} !== {1'b0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_setup_data got rdy=%b d=%h exp rdy=0 d=deadbeef", cmd_ready12, pwdata12);
        end
        tick();
        n_cmp++;
        if ({bus(), pwdata12, rsp_valid12} !== {4'b0010, 1'b1, 1'b1, 6'h04, 32'hDEADBEEF, 1'b0}) begin
            n_err++; $display("FAIL wr_access got bus=%h d=%h v=%b", bus(), pwdata12, rsp_valid12);
        end
        tick();
        n_cmp++;
        if ({rsp_valid12, rsp_err12, rsp_rdata12} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp got v=%b e=%b d=%h exp v=1 e=0 d=0", rsp_valid12, rsp_err12, rsp_rdata12);
        end
        n_cmp++;
        if ({bus(), cmd_ready12} !== {4'b0000, 1'b0, 1'b1, 6'h04, 1'b1}) begin
            n_err++; $display("FAIL wr_idle got bus=%h rdy=%b", bus(), cmd_ready12);
        end
        tick();
        n_cmp++;
        if (rsp_valid12 !== 1'b0) begin n_err++; $display("FAIL wr_pulse_len got %b exp 0", rsp_valid12); end
    endtask

    task automatic test_read();
        logic [7:0]  addrs [2] = '{8'hC8, 8'h3F};
        logic [3:0]  sels  [2] = '{4'b1000, 4'b0001};
        logic [31:0] datas [2] = '{32'h0000A5A5, 32'h33333333};
        for (int i = 0; i < 2; i++) begin
            cmd_valid12 = 1'b1; cmd_write12 = 1'b0; cmd_addr12 = addrs[i]; cmd_wdata12 = 32'h12345678;
            tick();
            cmd_valid12 = 1'b0;
            n_cmp++;
            if ({bus(), pwdata12} !== {sels[i], 1'b0, 1'b0, addrs[i][5:0], 32'h12345678}) begin
                n_err++; $display("FAIL rd_setup%0d got bus=%h d=%h exp sel=%b addr=%h", i, bus(), pwdata12, sels[i], addrs[i][5:0]);
            end
            tick(); tick();
            n_cmp++;
            if ({rsp_valid12, rsp_err12, rsp_rdata12} !== {1'b1, 1'b0, datas[i]}) begin
                n_err++; $display("FAIL rd_rsp%0d got v=%b e=%b d=%h exp d=%h", i, rsp_valid12, rsp_err12, rsp_rdata12, datas[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid12 = 1'b1; cmd_write12 = 1'b1; cmd_addr12 = 8'h85; cmd_wdata12 = 32'hAAAA0001;
        n_cmp++;
        if (cmd_ready12 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_idle got %b exp 1", cmd_ready12); end
        tick();
        cmd_write12 = 1'b0; cmd_addr12 = 8'h07; cmd_wdata12 = 32'hBBBB0002;
        n_cmp++;
        if ({bus(), cmd_ready12} !== {4'b0100, 1'b0, 1'b1, 6'h05, 1'b0}) begin
            n_err++; $display("FAIL b2b_setup1 got bus=%h rdy=%b", bus(), cmd_ready12);
        end
        tick();
        n_cmp++;
        if ({bus(), pwdata12, cmd_ready12} !== {4'b0100, 1'b1, 1'b1, 6'h05, 32'hAAAA0001, 1'b0}) begin
            n_err++; $display("FAIL b2b_access1 got bus=%h d=%h rdy=%b", bus(), pwdata12, cmd_ready12);
        end
        tick();
        n_cmp++;
        if ({rsp_valid12, cmd_ready12, psel12} !== {1'b1, 1'b1, 4'b0000}) begin
            n_err++; $display("FAIL b2b_done1 got v=%b rdy=%b sel=%b exp v=1 rdy=1 sel=0", rsp_valid12, cmd_ready12, psel12);
        end
        tick();
        cmd_valid12 = 1'b0;
        n_cmp++;
        if ({bus(), pwdata12} !== {4'b0001, 1'b0, 1'b0, 6'h07, 32'hBBBB0002}) begin
            n_err++; $display("FAIL b2b_setup2 got bus=%h d=%h", bus(), pwdata12);
        end
        tick(); tick();
        n_cmp++;
        if ({rsp_valid12, rsp_rdata12} !== {1'b1, 32'h33333333}) begin
            n_err++; $display("FAIL b2b_rsp2 got v=%b d=%h exp v=1 d=33333333", rsp_valid12, rsp_rdata12);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        cmd_valid12 = 1'b1; cmd_write12 = 1'b1; cmd_addr12 = 8'h40; cmd_wdata12 = 32'hCAFE0003;
        tick();
        cmd_valid12 = 1'b0;
        tick();
        n_cmp++;
        if (penable12 !== 1'b1) begin n_err++; $display("FAIL abort_in_access got %b exp 1", penable12); end
        p_reset12 = 1'b1;
        tick();
        p_reset12 = 1'b0;
        n_cmp++;
        if ({psel12, penable12, rsp_valid12} !== 6'b0) begin
            n_err++; $display("FAIL abort_state got sel=%b en=%b v=%b exp 0", psel12, penable12, rsp_valid12);
        end
        #1;
        n_cmp++;
        if (cmd_ready12 !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b exp 1", cmd_ready12); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid12 === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL abort_no_rsp got %0d pulses exp 0", pulses); end
    endtask

`ifdef APB_PREADY_EN
    // Runs one read of slave 1; pready rises in ACCESS cycle ready_at (0 = never).
    task automatic wait_xfer(input int ready_at, input int exp_len, input logic exp_err,
                             input logic [31:0] exp_data);
        int n = 0;
        cmd_valid12 = 1'b1; cmd_write12 = 1'b0; cmd_addr12 = 8'h42; cmd_wdata12 = 32'h0;
        pready12 = 1'b0;
        tick();
        cmd_valid12 = 1'b0;
        tick();
        while (penable12 === 1'b1 && n < 40) begin
            n++;
            pready12 = (ready_at != 0) && (n >= ready_at);
            tick();
        end
        pready12 = 1'b1;
        n_cmp++;
        if (n !== exp_len) begin n_err++; $display("FAIL wait_len%0d got %0d exp %0d", ready_at, n, exp_len); end
        n_cmp++;
        if ({rsp_valid12, rsp_err12, rsp_rdata12} !== {1'b1, exp_err, exp_data}) begin
            n_err++; $display("FAIL wait_rsp%0d got v=%b e=%b d=%h exp e=%b d=%h",
                              ready_at, rsp_valid12, rsp_err12, rsp_rdata12, exp_err, exp_data);
        end
        tick();
    endtask

    task automatic test_wait_states();
        wait_xfer(4, 4, 1'b0, 32'h22222222);
    endtask

    task automatic test_timeout();
        wait_xfer(0, 16, 1'b1, 32'h0);
        wait_xfer(16, 16, 1'b0, 32'h22222222);
    endtask
`endif

    initial begin
        prdata_bus12 = {32'h0000A5A5, 32'h11111111, 32'h22222222, 32'h33333333};
`ifdef APB_PREADY_EN
        pready12 = 1'b1;
`endif
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
`ifdef APB_PREADY_EN
        test_wait_states();
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
